pipe_stage_chain: RTL and testbench
===================================

// Module: pipe_stage_chain
// PURPOSE
//  Parametrised N-stage pipeline register chain with valid/ready flow control.
//  Replaces the fixed FD/DE/EM/MW registers of the five-stage processor.
//  Adds three things those registers lack:
//   - per-stage stall (bubble-collapsing backpressure)
//   - per-stage flush (kill)
//   - in-flight destination scoreboard for RAW hazard detection
//  Also keeps occupancy and stall performance counters.
// PARAMETERS
//  STAGES  4   number of register stages (>=2); stage 0 = entry, STAGES-1 = exit
//  WIDTH   16  payload width (instruction/control bundle)
//  REG_W   4   register-number width for dst/src fields
//  CNT_W   16  stall performance counter width
// PORTS
//  clk           in   1              rising-edge clock
//  reset         in   1              synchronous, active-high reset
//  in_valid      in   1              upstream item present
//  in_ready      out  1              stage 0 can accept this cycle
//  in_data       in   WIDTH          payload
//  in_dst        in   REG_W          destination register number of item
//  in_wen        in   1              item writes in_dst
//  src1_num      in   REG_W          source 1 of incoming item (hazard check)
//  src2_num      in   REG_W          source 2 of incoming item (hazard check)
//  hazard        out  1              incoming item reads a pending dst
//  hazard_stage  out  STAGES         one bit per stage holding a matching dst
//  flush         in   STAGES         bit k kills item currently in stage k
//  out_valid     out  1              exit stage holds a live item
//  out_ready     in   1              downstream accepts
//  out_data      out  WIDTH          exit-stage payload
//  out_dst       out  REG_W          exit-stage dst number
//  out_wen       out  1              exit-stage write enable
//  occupancy     out  $clog2(STAGES+1)  live items in chain
//  stall_cycles  out  CNT_W          saturating count of in_valid & !in_ready
// BEHAVIOUR
//  Reset
//   - All stage valid, data, dst and wen registers go to 0.
//   - occupancy = 0, stall_cycles = 0.
//   - in_ready = 1 after reset (chain empty).
//  Per-stage state: v[k], d[k], dst[k], wen[k].
//  Live item: live[k] = v[k] & ~flush[k].
//  Ready chain (combinational)
//   - rdy[STAGES] = out_ready
//   - rdy[k] = ~live[k] | rdy[k+1]
//   - in_ready = rdy[0]
//   - Bubbles collapse: an empty or flushed stage accepts even when downstream stalls.
//  Advance
//   - Stage k loads from stage k-1 (stage 0 from in_*) when rdy[k]=1.
//   - New v[k] = live[k-1] (stage 0: in_valid).
//   - When rdy[k]=0, stage k holds; a held flushed item becomes v[k]=0.
//  Latency: an unobstructed item appears at the output STAGES cycles after acceptance.
//   - Throughput is 1 per cycle.
//  Output
//   - out_valid = live[STAGES-1], combinational on flush.
//   - out_data, out_dst and out_wen are driven from stage STAGES-1.
//   - Transfer occurs when out_valid & out_ready.
//  Flush
//   - A flushed item never reaches a later stage or the output.
//   - flush does not affect an item entering stage k the same cycle.
//   - Flushing a stalled stage frees it the same cycle.
//   - flush and in_valid may be simultaneous: the new item enters stage 0 if
//     rdy[0], even when flush[0]=1 (flush[0] kills only the old occupant).
//  Hazard (combinational, advisory)
//   - hazard_stage[k] = live[k] & wen[k] & (dst[k]==src1_num | dst[k]==src2_num)
//   - hazard = in_valid & |hazard_stage
//   - The block never stalls on hazard; the issuing logic gates in_valid.
//  occupancy
//   - Equals the number of set v[k] after each edge.
//   - Invariant: occupancy == popcount(v); it never exceeds STAGES.
//  stall_cycles
//   - Increments on each cycle with in_valid & ~in_ready.
//   - Saturates at 2^CNT_W-1 and cleared only by reset.
//  Reset mid-operation: all in-flight items are discarded; no output transfer in the reset cycle.
// TESTING
//  1. Stream 8 items, out_ready=1 (STAGES=4): item i at output cycle i+4; occupancy settles at 4.
//  2. Fill chain, out_ready=0 for 3 cycles: in_ready=0, stall_cycles +3 with in_valid=1; data held exactly.
//  3. Bubble collapse: items in stages 0,2 only, out_ready=0: stage 1 fills next cycle; in_ready=1 once.
//  4. Flush: flush=4'b0110 with 4 live items: items from stages 1,2 never output; the other two do; occupancy drops by 2.
//  5. Hazard: stage 2 holds wen=1, dst=5; src1_num=5, in_valid=1 -> hazard=1, hazard_stage=4'b0100;
//     with wen=0 or flush[2]=1 -> hazard=0.
//  6. Assert reset with chain full: next cycle out_valid=0, occupancy=0, stall_cycles=0, in_ready=1.

Source files
------------

// File: rtl/pipe_stage_chain.sv
// rtl/pipe_stage_chain.sv - N-stage valid/ready pipeline register chain with flush, RAW scoreboard and counters
//
// Purpose: a chain of STAGES payload registers with bubble-collapsing backpressure,
// per-stage kill, an in-flight destination scoreboard for RAW hazard detection,
// an occupancy count and a saturating stall counter.
//
// Ports:
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   in_valid/in_ready          entry handshake; in_data/in_dst/in_wen is the entering item
//   src1_num, src2_num         sources of the incoming item, checked against pending dsts
//   hazard, hazard_stage       incoming item reads a pending dst / which stages match
//   flush                      bit k kills the item currently held in stage k
//   out_valid/out_ready        exit handshake; out_data/out_dst/out_wen from the last stage
//   occupancy                  number of occupied stage registers
//   stall_cycles               saturating count of cycles with in_valid & ~in_ready
module pipe_stage_chain #(
    parameter int STAGES = 4,
    parameter int WIDTH  = 16,
    parameter int REG_W  = 4,
    parameter int CNT_W  = 16,
    localparam int OCC_W = $clog2(STAGES + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    input  logic [REG_W-1:0]  in_dst,
    input  logic              in_wen,
    input  logic [REG_W-1:0]  src1_num,
    input  logic [REG_W-1:0]  src2_num,
    output logic              hazard,
    output logic [STAGES-1:0] hazard_stage,
    input  logic [STAGES-1:0] flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic [REG_W-1:0]  out_dst,
    output logic              out_wen,
    output logic [OCC_W-1:0]  occupancy,
    output logic [CNT_W-1:0]  stall_cycles
);

    logic [STAGES-1:0] v;
    logic [STAGES-1:0] wen_r;
    logic [WIDTH-1:0]  d   [STAGES];
    logic [REG_W-1:0]  dst [STAGES];

    logic [STAGES-1:0] live;
    logic [STAGES-1:0] rdy;

    // Ready ripples from the exit towards the entry. A stage is ready when it
    // is empty (or being killed) or when everything downstream of it can move,
    // so a bubble anywhere lets the stages above it advance.
    always_comb begin
        logic acc;
        live = v & ~flush;
        acc  = out_ready;
        rdy  = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            acc    = ~live[k] | acc;
            rdy[k] = acc;
        end
    end

    assign in_ready = rdy[0];

    // An item at the exit is not offered while reset is asserted, so nothing
    // transfers in the reset cycle.
    assign out_valid = live[STAGES-1] & ~reset;
    assign out_data  = d[STAGES-1];
    assign out_dst   = dst[STAGES-1];
    assign out_wen   = wen_r[STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            v     <= '0;
            wen_r <= '0;
            for (int k = 0; k < STAGES; k++) begin
                d[k]   <= '0;
                dst[k] <= '0;
            end
        end else begin
            if (rdy[0]) begin
                v[0]     <= in_valid;
                d[0]     <= in_data;
                dst[0]   <= in_dst;
                wen_r[0] <= in_wen;
            end
            for (int k = 1; k < STAGES; k++) begin
                if (rdy[k]) begin
                    // A killed upstream item arrives as a bubble.
                    v[k]     <= live[k-1];
                    d[k]     <= d[k-1];
                    dst[k]   <= dst[k-1];
                    wen_r[k] <= wen_r[k-1];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if (in_valid && !in_ready && (stall_cycles != {CNT_W{1'b1}})) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end

    always_comb begin
        logic [OCC_W-1:0] cnt;
        cnt = '0;
        for (int k = 0; k < STAGES; k++) begin
            cnt = cnt + OCC_W'(v[k]);
        end
        occupancy = cnt;
    end

    // Advisory only: the issuing logic decides whether to hold in_valid back.
    always_comb begin
        hazard_stage = '0;
        for (int k = 0; k < STAGES; k++) begin
            hazard_stage[k] = live[k] & wen_r[k] &
                              ((dst[k] == src1_num) | (dst[k] == src2_num));
        end
    end

    assign hazard = in_valid & (|hazard_stage);

endmodule

// File: tb/tb_pipe_stage_chain.sv
// tb/tb_pipe_stage_chain.sv - self-checking bench for pipe_stage_chain
module tb_pipe_stage_chain;

    localparam int S     = 4;
    localparam int W     = 16;
    localparam int RW    = 4;
    localparam int CW    = 4;
    localparam int OCC_W = $clog2(S + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic [RW-1:0] in_dst;
    logic          in_wen;
    logic [RW-1:0] src1_num;
    logic [RW-1:0] src2_num;
    logic          hazard;
    logic [S-1:0]  hazard_stage;
    logic [S-1:0]  flush;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [RW-1:0] out_dst;
    logic          out_wen;
    logic [OCC_W-1:0] occupancy;
    logic [CW-1:0] stall_cycles;

    pipe_stage_chain #(.STAGES(S), .WIDTH(W), .REG_W(RW), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_dst(in_dst), .in_wen(in_wen),
        .src1_num(src1_num), .src2_num(src2_num),
        .hazard(hazard), .hazard_stage(hazard_stage),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_dst(out_dst), .out_wen(out_wen),
        .occupancy(occupancy), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // Reference: S slots holding whole items; each cycle killed items vanish,
    // the exit item leaves if taken, items slide forward into free slots, and
    // a new item drops into slot 0 if it ended up free.
    bit            mv   [S];
    logic [W-1:0]  md   [S];
    logic [RW-1:0] mdst [S];
    bit            mwen [S];
    int            mstall;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic bit model_in_ready();
        bit occ [S];
        for (int k = 0; k < S; k++) occ[k] = mv[k] && !flush[k];
        if (out_ready) occ[S-1] = 0;
        for (int k = S - 2; k >= 0; k--) begin
            if (occ[k] && !occ[k+1]) begin
                occ[k+1] = 1;
                occ[k]   = 0;
            end
        end
        return !occ[0];
    endfunction

    task automatic model_step();
        bit rdy0;
        if (reset) begin
            for (int k = 0; k < S; k++) mv[k] = 0;
            mstall = 0;
            return;
        end
        rdy0 = model_in_ready();
        if (in_valid && !rdy0 && mstall < (1 << CW) - 1) mstall++;
        for (int k = 0; k < S; k++) if (flush[k]) mv[k] = 0;
        if (out_ready) mv[S-1] = 0;
        for (int k = S - 2; k >= 0; k--) begin
            if (mv[k] && !mv[k+1]) begin
                mv[k+1] = 1; md[k+1] = md[k]; mdst[k+1] = mdst[k]; mwen[k+1] = mwen[k];
                mv[k] = 0;
            end
        end
        if (!mv[0] && in_valid) begin
            mv[0] = 1; md[0] = in_data; mdst[0] = in_dst; mwen[0] = in_wen;
        end
    endtask

    // Compare every output with the reference mid-cycle, then advance both.
    task automatic cycle();
        bit            ev;
        logic [S-1:0]  hs;
        int            pop;
        @(negedge clk);
        ev  = mv[S-1] && !flush[S-1] && !reset;
        hs  = '0;
        pop = 0;
        for (int k = 0; k < S; k++) begin
            hs[k] = mv[k] && !flush[k] && mwen[k] && (mdst[k] == src1_num || mdst[k] == src2_num);
            pop += int'(mv[k]);
        end
        check("out_valid", 32'(out_valid), 32'(ev));
        if (ev) begin
            check("out_data", 32'(out_data), 32'(md[S-1]));
            check("out_dst",  32'(out_dst),  32'(mdst[S-1]));
            check("out_wen",  32'(out_wen),  32'(mwen[S-1]));
        end
        check("in_ready",     32'(in_ready),     32'(model_in_ready()));
        check("hazard_stage", 32'(hazard_stage), 32'(hs));
        check("hazard",       32'(hazard),       32'(in_valid && (hs != 0)));
        check("occupancy",    32'(occupancy),    32'(pop));
        check("stall_cycles", 32'(stall_cycles), 32'(mstall));
        @(posedge clk);
        model_step();
        #1;
    endtask

    initial begin
        int s0;
        reset = 1; in_valid = 0; in_data = '0; in_dst = '0; in_wen = 0;
        src1_num = '0; src2_num = '0; flush = '0; out_ready = 1;
        for (int k = 0; k < S; k++) begin mv[k] = 0; md[k] = '0; mdst[k] = '0; mwen[k] = 0; end
        mstall = 0;
        cycle();
        reset = 0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_occupancy", 32'(occupancy), 32'd0);
        check("rst_stall",     32'(stall_cycles), 32'd0);
        check("rst_in_ready",  32'(in_ready), 32'd1);

        // Stream 8 items unobstructed: item i appears at cycle i+4.
        src1_num = 4'hF; src2_num = 4'hF;
        for (int c = 0; c < 13; c++) begin
            in_valid = (c < 8);
            in_data  = W'(16'hA000 + c);
            in_dst   = RW'(c);
            in_wen   = 0;
            #1;
            check("lat_valid", 32'(out_valid), 32'((c >= 4 && c < 12) ? 1 : 0));
            if (c >= 4 && c < 12) check("lat_data", 32'(out_data), 32'(16'hA000 + c - 4));
            if (c >= 4 && c <= 8) check("lat_occ", 32'(occupancy), 32'd4);
            cycle();
        end

        // Fill with the exit blocked, then stall three more cycles.
        out_ready = 0; in_valid = 1;
        for (int c = 0; c < 4; c++) begin
            in_data = W'(16'hB000 + c); in_dst = RW'(c); in_wen = 1;
            cycle();
        end
        s0 = mstall;
        for (int c = 0; c < 3; c++) begin
            in_data = W'(16'hBF00 + c);
            #1;
            check("full_in_ready", 32'(in_ready), 32'd0);
            check("full_held", 32'(out_data), 32'h0000B000);
            cycle();
        end
        check("stall_plus3", 32'(stall_cycles), 32'(s0 + 3));

        // Kill the two middle items of a full chain.
        in_valid = 0; flush = 4'b0110;
        cycle();
        flush = '0;
        #1;
        check("flush_occ", 32'(occupancy), 32'd2);
        out_ready = 1;
        for (int c = 0; c < 4; c++) cycle();

        // Hazard: wen=1, dst=5 item parked in stage 2.
        in_valid = 1; in_data = 16'h5555; in_dst = 4'd5; in_wen = 1;
        cycle();
        in_valid = 0; in_wen = 0; in_dst = 4'd0;
        cycle();
        cycle();
        in_valid = 1; src1_num = 4'd5; src2_num = 4'd9; out_ready = 0;
        #1;
        check("haz_hit", 32'(hazard), 32'd1);
        check("haz_stage", 32'(hazard_stage), 32'h4);
        flush = 4'b0100;
        #1;
        check("haz_flushed", 32'(hazard), 32'd0);
        cycle();
        flush = '0;

        // Randomised traffic.
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = W'($urandom);
            in_dst    = RW'($urandom_range(0, 7));
            in_wen    = $urandom_range(0, 1) == 1;
            src1_num  = RW'($urandom_range(0, 7));
            src2_num  = RW'($urandom_range(0, 7));
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 5) == 0) ? S'($urandom) : '0;
            cycle();
        end

        // Reset with the chain full.
        flush = '0; out_ready = 0; in_valid = 1;
        for (int c = 0; c < 5; c++) cycle();
        reset = 1;
        cycle();
        reset = 0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_occ", 32'(occupancy), 32'd0);
        check("mid_rst_stall", 32'(stall_cycles), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        in_valid = 0;
        cycle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
